// File: rtl/pe_array_scheduler_pkg.sv
// Shared types and widths for the PE array scheduler.
package pe_sched_pkg;

  // Width of the task index and layer index presented to each PE.
  localparam int TASK_W = 32;

  // Scheduler control states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISPATCH  = 2'd1,
    LAYER_END = 2'd2,
    FINISH    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/pe_array_scheduler_if.sv
// Scheduler <-> PE array bundle: run control in, per-PE start/task out, done pulses back.
interface pe_array_scheduler_if #(
  parameter int NUM_PE = 4
);
  import pe_sched_pkg::*;

  logic              start;
  logic [NUM_PE-1:0] pe_done;
  logic [NUM_PE-1:0] pe_start;
  logic [TASK_W-1:0] pe_task [0:NUM_PE-1];
  logic [TASK_W-1:0] layer_num;
  logic              layer_done;
  logic              busy;
  logic              done;

  // Side that launches runs and returns PE completions.
  modport master (
    output start, pe_done,
    input  pe_start, pe_task, layer_num, layer_done, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, pe_done,
    output pe_start, pe_task, layer_num, layer_done, busy, done
  );

endinterface

// File: rtl/pe_array_scheduler_idle_pe_arbiter.sv
// Lowest-index priority select over the idle PEs.
module idle_pe_arbiter #(
  parameter int NUM_PE = 4
) (
  input  logic [NUM_PE-1:0] i_busy_pe,
  output logic [NUM_PE-1:0] o_grant,
  output logic              o_valid
);

  // Scan upward and grant the first PE that is not busy.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (!i_busy_pe[i] && !o_valid) begin
        o_grant[i] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_array_scheduler.sv
// Hands layer tasks to idle PEs, counts completions and enforces a barrier between layers.
module pe_array_scheduler
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE          = 4,
  parameter int NUM_LAYERS      = 3,
  parameter int TASKS_PER_LAYER = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_array_scheduler_if.slave  bus
);

  localparam int                CNT_W      = $clog2(TASKS_PER_LAYER + 1);
  localparam logic [CNT_W-1:0]  TASKS_C    = CNT_W'(TASKS_PER_LAYER);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [TASK_W-1:0] LAST_LAYER = TASK_W'(NUM_LAYERS - 1);
  localparam logic [TASK_W-1:0] LAYER_ONE  = TASK_W'(1);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;

  logic [NUM_PE-1:0] r_busy_pe;
  logic [NUM_PE-1:0] r_pe_start;
  logic [TASK_W-1:0] r_pe_task [0:NUM_PE-1];
  logic [TASK_W-1:0] r_layer_num;
  logic [CNT_W-1:0]  r_next_task;
  logic [CNT_W-1:0]  r_completed;

  logic [NUM_PE-1:0] w_grant;
  logic              w_grant_vld;
  logic [NUM_PE-1:0] w_valid_done;
  logic [CNT_W-1:0]  w_done_cnt;
  logic [CNT_W-1:0]  w_completed_sum;
  logic              w_dispatch;
  logic              w_layer_complete;
  logic              w_last_layer;
  logic              w_busy;
  logic              w_layer_done;
  logic              w_done;

  // Eligibility comes from the registered mask, so a PE finishing this
  // cycle only becomes a candidate on the following cycle.
  idle_pe_arbiter #(
    .NUM_PE (NUM_PE)
  ) u_arb (
    .i_busy_pe (r_busy_pe),
    .o_grant   (w_grant),
    .o_valid   (w_grant_vld)
  );

  // Qualify completions against the busy mask, count them, and decide on a dispatch.
  always_comb begin
    w_valid_done = bus.pe_done & r_busy_pe;
    w_done_cnt   = '0;
    for (int j = 0; j < NUM_PE; j++) begin
      w_done_cnt = w_done_cnt + CNT_W'(w_valid_done[j]);
    end
    // Valid dones never exceed the outstanding tasks, so the sum stays <= TASKS_PER_LAYER.
    w_completed_sum  = r_completed + w_done_cnt;
    w_dispatch       = (r_state == DISPATCH) && w_grant_vld && (r_next_task < TASKS_C);
    w_layer_complete = (w_completed_sum == TASKS_C);
    w_last_layer     = (r_layer_num == LAST_LAYER);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (bus.start) w_state_nxt = DISPATCH;
      DISPATCH:  if (w_layer_complete) w_state_nxt = LAYER_END;
      LAYER_END: w_state_nxt = w_last_layer ? FINISH : DISPATCH;
      FINISH:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // State-decoded status outputs; they come straight off the state register.
  always_comb begin
    w_busy       = (r_state != IDLE);
    w_layer_done = (r_state == LAYER_END);
    w_done       = (r_state == FINISH);
  end

  // Task counters, busy mask, per-PE start/task registers and layer index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_pe   <= '0;
      r_pe_start  <= '0;
      r_next_task <= '0;
      r_completed <= '0;
      r_layer_num <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        r_pe_task[i] <= '0;
      end
    end else begin
      r_pe_start <= '0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_layer_num <= '0;
            r_next_task <= '0;
            r_completed <= '0;
            r_busy_pe   <= '0;
          end
        end
        DISPATCH: begin
          // Granted PE is idle in the registered mask, so it never overlaps a valid done.
          r_busy_pe   <= (r_busy_pe & ~w_valid_done) | (w_dispatch ? w_grant : '0);
          r_completed <= w_completed_sum;
          if (w_dispatch) begin
            r_pe_start  <= w_grant;
            r_next_task <= r_next_task + CNT_ONE;
            for (int i = 0; i < NUM_PE; i++) begin
              if (w_grant[i]) begin
                r_pe_task[i] <= TASK_W'(r_next_task);
              end
            end
          end
        end
        LAYER_END: begin
          // Final layer keeps its index visible until the next run starts.
          if (!w_last_layer) begin
            r_layer_num <= r_layer_num + LAYER_ONE;
            r_next_task <= '0;
            r_completed <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pe_start   = r_pe_start;
  assign bus.pe_task    = r_pe_task;
  assign bus.layer_num  = r_layer_num;
  assign bus.layer_done = w_layer_done;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Bench for pe_array_scheduler: table-driven start-up, directed corner sequences and
// randomized runs compared every cycle against a behavioural scheduler model.
module tb_pe_array_scheduler;
  import pe_sched_pkg::*;

  localparam int NPE = 4;
  localparam int NL  = 3;
  localparam int T   = 8;
  localparam int H   = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_array_scheduler_if #(.NUM_PE(NPE)) bus ();

  pe_array_scheduler #(
    .NUM_PE          (NPE),
    .NUM_LAYERS      (NL),
    .TASKS_PER_LAYER (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = -100;

  // Stimulus controls.
  bit         start_in;
  bit         rst_in;
  logic [3:0] force_done;
  bit         rand_spur;
  int         pe_lat;
  int         timer [NPE];

  // Outputs sampled in the current cycle.
  logic [3:0]  s_start;
  logic [31:0] s_task [NPE];
  logic [31:0] s_layer;
  logic        s_ld, s_busy, s_done;

  // Behavioural model state and its predicted outputs for the next cycle.
  int          m_ph;
  int          m_layer, m_next, m_cnt;
  logic [3:0]  m_busy;
  logic [3:0]  e_start;
  logic [31:0] e_task [NPE];
  logic [31:0] e_layer;
  logic        e_ld, e_busy, e_done;

  // Per-cycle history for timing analysis within a scenario.
  logic [3:0]  h_start [H];
  logic [31:0] h_layer [H];
  logic        h_ld    [H];
  logic        h_done  [H];
  logic        h_busy  [H];
  logic [31:0] h_task  [H][NPE];

  typedef struct {
    bit         start;
    logic [3:0] exp_start;
    int         tpe;
    int         ttask;
    bit         exp_busy;
  } vec_t;
  vec_t tbl [10];

  function automatic int ix(input int c);
    return (c < 0) ? 0 : ((c >= H) ? H - 1 : c);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference scheduler: a task list per layer handed to the lowest free PE,
  // a completion tally, and a barrier/finish phase; predicts next-cycle outputs.
  task automatic model_update(input bit r, input bit s, input logic [3:0] d);
    int pick;
    e_start = '0;
    if (r) begin
      m_ph = 0; m_layer = 0; m_next = 0; m_cnt = 0; m_busy = '0;
      for (int i = 0; i < NPE; i++) e_task[i] = '0;
    end else begin
      case (m_ph)
        0: if (s) begin
          m_ph = 1; m_layer = 0; m_next = 0; m_cnt = 0; m_busy = '0;
        end
        1: begin
          pick = -1;
          if (m_next < T)
            for (int i = NPE - 1; i >= 0; i--) if (!m_busy[i]) pick = i;
          m_cnt  += $countones(d & m_busy);
          m_busy &= ~d;
          if (pick >= 0) begin
            e_start[pick] = 1'b1;
            e_task[pick]  = m_next;
            m_next++;
            m_busy[pick] = 1'b1;
          end
          if (m_cnt == T) m_ph = 2;
        end
        2: begin
          if (m_layer == NL - 1) m_ph = 3;
          else begin
            m_layer++; m_next = 0; m_cnt = 0; m_ph = 1;
          end
        end
        default: m_ph = 0;
      endcase
    end
    e_layer = m_layer;
    e_ld    = (m_ph == 2);
    e_busy  = (m_ph != 0);
    e_done  = (m_ph == 3);
  endtask

  // One clock cycle: sample and compare outputs, run the PE models, drive inputs.
  task automatic step();
    logic [3:0] d;
    logic [3:0] spur;
    @(negedge clk);
    s_start = bus.pe_start;
    s_layer = bus.layer_num;
    s_ld    = bus.layer_done;
    s_busy  = bus.busy;
    s_done  = bus.done;
    for (int i = 0; i < NPE; i++) s_task[i] = bus.pe_task[i];
    chk("model_ctl", {s_start, s_layer, s_ld, s_busy, s_done},
                     {e_start, e_layer, e_ld, e_busy, e_done});
    chk("model_task", {s_task[3], s_task[2], s_task[1], s_task[0]},
                      {e_task[3], e_task[2], e_task[1], e_task[0]});
    if (cyc >= 0 && cyc < H) begin
      h_start[cyc] = s_start; h_layer[cyc] = s_layer; h_ld[cyc] = s_ld;
      h_done[cyc]  = s_done;  h_busy[cyc]  = s_busy;
      for (int i = 0; i < NPE; i++) h_task[cyc][i] = s_task[i];
    end
    d = '0;
    for (int i = 0; i < NPE; i++) begin
      if (timer[i] > 0) begin
        timer[i]--;
        if (timer[i] == 0) d[i] = 1'b1;
      end
    end
    for (int i = 0; i < NPE; i++)
      if (s_start[i]) timer[i] = (pe_lat == 0) ? int'($urandom_range(1, 8)) : pe_lat;
    for (int i = 0; i < NPE; i++)
      if (force_done[i]) timer[i] = 0;
    d |= force_done;
    if (rand_spur && $urandom_range(0, 7) == 0) begin
      spur = 4'($urandom);
      for (int i = 0; i < NPE; i++) if (timer[i] != 0) spur[i] = 1'b0;
      d |= spur;
    end
    rst         = rst_in;
    bus.start   = start_in;
    bus.pe_done = d;
    model_update(rst_in, start_in, d);
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NPE; i++) timer[i] = 0;
    rst_in = 1'b1; start_in = 1'b0; force_done = '0;
    step();
    step();
    chk("reset_ctl", {s_start, s_layer, s_ld, s_busy, s_done}, '0);
    chk("reset_task", {s_task[3], s_task[2], s_task[1], s_task[0]}, '0);
    rst_in = 1'b0;
    cyc    = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, t1, t, cs, nst, nld, ndone, tf, lastld;
    logic [3:0] gap;
    logic [31:0] last_task;

    rst = 1'b1; bus.start = 1'b0; bus.pe_done = '0;
    start_in = 1'b0; rst_in = 1'b1; force_done = '0; rand_spur = 1'b0; pe_lat = 5;
    for (int i = 0; i < NPE; i++) timer[i] = 0;
    model_update(1'b1, 1'b0, '0);

    // Start-up: four PEs fill on consecutive cycles, PE0 refills two cycles after its done.
    tbl[0] = '{1'b1, 4'b0000, -1, 0, 1'b0};
    tbl[1] = '{1'b0, 4'b0000, -1, 0, 1'b1};
    tbl[2] = '{1'b0, 4'b0001,  0, 0, 1'b1};
    tbl[3] = '{1'b0, 4'b0010,  1, 1, 1'b1};
    tbl[4] = '{1'b0, 4'b0100,  2, 2, 1'b1};
    tbl[5] = '{1'b0, 4'b1000,  3, 3, 1'b1};
    tbl[6] = '{1'b0, 4'b0000, -1, 0, 1'b1};
    tbl[7] = '{1'b0, 4'b0000, -1, 0, 1'b1};
    tbl[8] = '{1'b0, 4'b0000, -1, 0, 1'b1};
    tbl[9] = '{1'b0, 4'b0001,  0, 4, 1'b1};

    pe_lat = 5;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      start_in = tbl[r].start;
      step();
      start_in = 1'b0;
      chk("tbl_pe_start", s_start, tbl[r].exp_start);
      chk("tbl_busy", s_busy, tbl[r].exp_busy);
      if (tbl[r].tpe >= 0) chk("tbl_pe_task", s_task[tbl[r].tpe], tbl[r].ttask);
    end

    // Two PEs finishing in the same cycle: both counted, re-dispatched PE1 then PE2.
    pe_lat = 1000;
    do_reset();
    start_in = 1'b1; step(); start_in = 1'b0;       // cycle 0
    repeat (5) step();                              // cycles 1..5
    force_done = 4'b0110; step(); force_done = '0;  // cycle 6
    step(); chk("dual_gap", s_start, 4'b0000);      // cycle 7
    step(); chk("dual_first", s_start, 4'b0010);    // cycle 8
    chk("dual_task1", s_task[1], 4);
    step(); chk("dual_second", s_start, 4'b0100);   // cycle 9
    chk("dual_task2", s_task[2], 5);
    force_done = 4'b1111; step(); force_done = '0;  // cycle 10
    repeat (4) step();                              // cycles 11..14
    force_done = 4'b0011; step(); force_done = '0;  // cycle 15
    chk("dual_no_early_ld", s_ld, 1'b0);
    step(); chk("dual_layer_done", s_ld, 1'b1);     // cycle 16

    // Layer barrier.
    pe_lat = 5;
    do_reset();
    start_in = 1'b1; step(); start_in = 1'b0;
    n = 0;
    while (!s_ld && n < 300) begin step(); n++; end
    chk("barrier_ld_seen", s_ld, 1'b1);
    t1 = cyc - 1;
    repeat (3) step();
    nst = 0; cs = -1;
    for (int c = 0; c <= t1 && c < H; c++)
      if (h_start[c] != 0) begin nst += $countones(h_start[c]); cs = c; end
    chk("barrier_nstarts", nst, T);
    last_task = '1;
    for (int i = 0; i < NPE; i++) if (h_start[ix(cs)][i]) last_task = h_task[ix(cs)][i];
    chk("barrier_last_task", last_task, T - 1);
    t = cs + 5;
    chk("barrier_ld_t", h_ld[ix(t)], 1'b0);
    chk("barrier_ld_t1", h_ld[ix(t + 1)], 1'b1);
    chk("barrier_layer_t1", h_layer[ix(t + 1)], 0);
    chk("barrier_layer_t2", h_layer[ix(t + 2)], 1);
    chk("barrier_restart", h_start[ix(t + 3)], 4'b0001);
    chk("barrier_task0", h_task[ix(t + 3)][0], 0);
    gap = '0;
    for (int c = cs + 1; c <= t + 2; c++) gap |= h_start[ix(c)];
    chk("barrier_gap", gap, 4'b0000);

    // Spurious done on an idle PE.
    pe_lat = 5;
    do_reset();
    start_in = 1'b1; step(); start_in = 1'b0;        // cycle 0
    step(); step();                                  // cycles 1,2
    force_done = 4'b1000; step(); force_done = '0;   // cycle 3, PE3 still idle
    n = 0;
    while (!s_ld && n < 300) begin step(); n++; end
    chk("spur_ld_seen", s_ld, 1'b1);
    t1 = cyc - 1;
    nst = 0;
    for (int c = 0; c <= t1 && c < H; c++) nst += $countones(h_start[c]);
    chk("spur_nstarts", nst, T);
    chk("spur_ld_cycle", t1, 18);

    // Reset in the middle of layer 1.
    pe_lat = 5;
    do_reset();
    start_in = 1'b1; step(); start_in = 1'b0;
    n = 0;
    while (s_layer != 1 && n < 300) begin step(); n++; end
    chk("rst_reached_layer1", s_layer, 1);
    repeat (3) step();
    rst_in = 1'b1; step(); rst_in = 1'b0;
    step();
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_layer", s_layer, 0);
    chk("rst_pe_start", s_start, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rst_quiet", {s_busy, s_start}, 5'b0);
    end
    start_in = 1'b1; step(); start_in = 1'b0;
    step(); step();
    chk("rst_restart", s_start, 4'b0001);
    chk("rst_restart_task", s_task[0], 0);
    chk("rst_restart_layer", s_layer, 0);

    // Full run with start re-asserted while busy.
    pe_lat = 5;
    do_reset();
    start_in = 1'b1; step();
    n = 0;
    while (!s_done && n < 600) begin
      start_in = ($urandom_range(0, 3) == 0);
      step();
      n++;
    end
    start_in = 1'b0;
    chk("full_done_seen", s_done, 1'b1);
    tf = cyc - 1;
    step();
    chk("full_idle_after", s_busy, 1'b0);
    nst = 0; nld = 0; ndone = 0; lastld = -1;
    for (int c = 0; c <= tf + 1 && c < H; c++) begin
      nst += $countones(h_start[c]);
      if (h_ld[c]) begin nld++; lastld = c; end
      if (h_done[c]) ndone++;
    end
    chk("full_nstarts", nst, NL * T);
    chk("full_nlayer_done", nld, NL);
    chk("full_ndone", ndone, 1);
    chk("full_done_after_ld", lastld + 1, tf);

    // Randomized runs: random PE latencies, spurious dones on idle PEs, stray starts.
    for (int run = 0; run < 6; run++) begin
      pe_lat = 0;
      rand_spur = 1'b1;
      do_reset();
      start_in = 1'b1; step();
      n = 0;
      while (!s_done && n < 1500) begin
        start_in = ($urandom_range(0, 4) == 0);
        step();
        n++;
      end
      start_in = 1'b0;
      chk("rand_done_seen", s_done, 1'b1);
      rand_spur = 1'b0;
      repeat (3) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pe_array_scheduler.md
Name: pe_array_scheduler

Overview:
- Sequences an array of NUM_PE convolution processing elements (`pe` instances) across NUM_LAYERS layers.
- Each layer has TASKS_PER_LAYER independent tasks, e.g. output-channel or filter groups.
- The scheduler hands tasks to idle PEs and collects their done pulses.
- It enforces a barrier at each layer boundary, and drives each PE's start, task number (pe_num) and layer_num.

Parameters:
NUM_PE, 4, number of PE instances served
NUM_LAYERS, 3, number of layers per run
TASKS_PER_LAYER, 8, tasks dispatched per layer (>= 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
pe_done  input  NUM_PE  per-PE one-cycle completion pulse
pe_start  output  NUM_PE  per-PE one-cycle start pulse, registered
pe_task  output  32 x NUM_PE (unpacked [31:0] pe_task[0:NUM_PE-1])  task index for each PE, registered; stable while that PE is busy
layer_num  output  32  current layer index, registered
layer_done  output  1  one-cycle pulse when all tasks of a layer have completed
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of run

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - At reset: state=IDLE, all outputs 0, internal busy_pe mask 0, next_task=0, completed=0.
  - Reset asserted mid-operation takes effect at the next edge; no pending start or done is retained.
- States: IDLE, DISPATCH, LAYER_END, FINISH.
- IDLE:
  - start=1 → DISPATCH with layer_num=0, next_task=0, completed=0.
  - start in any other state is ignored.
- DISPATCH, each cycle:
  - Dispatch condition: next_task < TASKS_PER_LAYER and the registered busy_pe mask has an idle PE.
  - If met, select the lowest-index idle PE i. At the edge: pe_start[i]<=1, pe_task[i]<=next_task, busy_pe[i]<=1, next_task++.
  - At most one dispatch per cycle.
  - pe_start is 0 in every cycle where no dispatch was registered.
  - Each pe_done[j] with busy_pe[j]=1 clears busy_pe[j] and adds 1 to completed. Multiple dones in one cycle are counted by popcount.
  - pe_done[j] on a non-busy PE is ignored.
  - A PE that raises done in cycle t is not eligible for dispatch in cycle t, because eligibility uses the registered mask. It is eligible from cycle t+1.
  - When completed + valid dones this cycle == TASKS_PER_LAYER → LAYER_END.
- LAYER_END (one cycle):
  - layer_done=1.
  - If layer_num == NUM_LAYERS-1 → FINISH.
  - Otherwise layer_num++, next_task=0, completed=0 → DISPATCH.
  - No task of layer L+1 is started before every task of layer L is done (barrier).
- FINISH (one cycle): done=1 → IDLE. layer_num holds its final value until the next start.
- Latency:
  - start high in cycle c → DISPATCH in c+1 → pe_start[0] with pe_task[0]=0 in c+2.
  - Subsequent dispatches, when PEs are available, in c+3, c+4, …
  - Last valid done in cycle t → layer_done in t+1 → first pe_start of the next layer in t+3.
- Widths:
  - next_task and completed are $clog2(TASKS_PER_LAYER+1) bits. They never wrap, because they saturate at TASKS_PER_LAYER by construction.
  - pe_task is zero-extended to 32 bits.
- Case TASKS_PER_LAYER < NUM_PE: the higher-index PEs are never started in that layer.

Decomposition:
- Package pe_sched_pkg holds:
  - sched_state_t enum (IDLE, DISPATCH, LAYER_END, FINISH);
  - a localparam for the 32-bit task/layer width.
- One sub-module, idle_pe_arbiter: combinational lowest-index priority select over ~busy_pe. Outputs a one-hot grant plus a valid bit.
- Counters and the FSM stay in pe_array_scheduler.

Test Plan:
All scenarios use defaults (NUM_PE=4, TASKS_PER_LAYER=8, NUM_LAYERS=3) with a PE model that pulses done 5 cycles after its start.
- Reset, then start in cycle 0 → pe_start[0..3] in cycles 2,3,4,5 with pe_task 0,1,2,3. PE0 done in cycle 7 → pe_start[0] with pe_task[0]=4 in cycle 9.
- Force pe_done[1] and pe_done[2] in the same cycle → completed +2. PE1 and PE2 are re-dispatched on consecutive cycles, PE1 first, tasks consecutive.
- Layer barrier: done of task 7 of layer 0 in cycle t → layer_done=1 in t+1, layer_num=1 from t+2, pe_start[0] with pe_task=0 in t+3. No pe_start between task 7's start and t+3.
- Spurious pe_done[3] while PE3 is idle → completed unchanged, no extra dispatch, layer finishes with exactly 8 starts.
- Assert rst for one cycle mid-layer 1 → next cycle: busy=0, layer_num=0, pe_start=0. Later pe_done pulses are ignored. A new start restarts at layer 0, task 0.
- Full run, with start re-asserted while busy (ignored) → exactly 24 pe_start pulses and 3 layer_done pulses. done=1 for exactly one cycle, the cycle after the third layer_done; then busy=0.
